multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time, using the instruction register output.
- Drives the immediate generator's ImmSel, the datapath mux selects and the register/memory write enables.
- Handshakes with instruction/data memory through MemReady, traps illegal encodings and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// drives datapath selects and write enables, traps illegal encodings, counts retirements.
module multicycle_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Inst,
    input  logic            MemReady,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic [2:0]      ImmSel,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCSel,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWEn,
    output logic [1:0]      WBSel,
    output logic            ASel,
    output logic            BSel,
    output logic [1:0]      ALUOp,
    output logic            BrUn,
    output logic            Illegal,
    output logic [XLEN-1:0] InstRet,
    output logic [2:0]      State
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui;
    logic       legal, taken, retire;
    logic [2:0] imm_sel;
    logic       inst_unused;

    assign opcode      = Inst[6:0];
    assign funct3      = Inst[14:12];
    assign inst_unused = ^{Inst[XLEN-1:15], Inst[11:7]};

    assign is_r    = (opcode == 7'b0110011);
    assign is_i    = (opcode == 7'b0010011);
    assign is_ld   = (opcode == 7'b0000011);
    assign is_st   = (opcode == 7'b0100011);
    assign is_br   = (opcode == 7'b1100011);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_jalr = (opcode == 7'b1100111);
    assign is_lui  = (opcode == 7'b0110111);
    assign is_aui  = (opcode == 7'b0010111);

    // funct3 010/011 has no branch encoding, so it traps like an unknown opcode
    assign legal = (is_r | is_i | is_ld | is_st | is_jal | is_jalr | is_lui | is_aui)
                 | (is_br & (funct3[2:1] != 2'b01));

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:          taken = BrEq;
            3'b001:          taken = ~BrEq;
            3'b100, 3'b110:  taken = BrLT;
            3'b101, 3'b111:  taken = ~BrLT;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_sel = 3'b000;
        if (is_st)                 imm_sel = 3'b001;
        else if (is_br)            imm_sel = 3'b010;
        else if (is_jal)           imm_sel = 3'b100;
        else if (is_lui | is_aui)  imm_sel = 3'b101;
    end

    always_comb begin
        state_d  = state_q;
        ImmSel   = 3'b000;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSel    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWEn   = 1'b0;
        WBSel    = 2'b00;
        ASel     = 1'b0;
        BSel     = 1'b0;
        ALUOp    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ImmSel  = imm_sel;
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                ImmSel = imm_sel;
                BSel   = ~is_r;
                ASel   = is_br | is_jal | is_aui;
                if (is_r | is_i) ALUOp = 2'b10;
                else if (is_lui) ALUOp = 2'b11;
                if ((is_br & taken) | is_jal | is_jalr) begin
                    PCWrite = 1'b1;
                    PCSel   = 1'b1;
                end
                if (is_ld | is_st)  state_d = S_MEM;
                else if (is_br)     state_d = S_FETCH;
                else                state_d = S_WB;
            end
            S_MEM: begin
                MemRead  = is_ld;
                MemWrite = is_st;
                if (MemReady) state_d = is_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                RegWEn = 1'b1;
                if (is_ld)                WBSel = 2'b01;
                else if (is_jal | is_jalr) WBSel = 2'b10;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign retire    = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                     && (state_d == S_FETCH);
    assign instret_d = retire ? instret_q + XLEN'(1) : instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign BrUn    = Inst[13];
    assign Illegal = (state_q == S_TRAP);
    assign InstRet = instret_q;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle
// output records from its class and stall schedule; a negedge process compares them.
module tb_multicycle_ctrl;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
    localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUI = 8, C_ILL = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Inst = 32'h0;
    logic        MemReady = 1'b0;
    logic        BrEq = 1'b0;
    logic        BrLT = 1'b0;
    logic [2:0]  ImmSel;
    logic        IRWrite, PCWrite, PCSel, MemRead, MemWrite, RegWEn;
    logic [1:0]  WBSel;
    logic        ASel, BSel;
    logic [1:0]  ALUOp;
    logic        BrUn, Illegal;
    logic [31:0] InstRet;
    logic [2:0]  State;

    multicycle_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Inst(Inst), .MemReady(MemReady), .BrEq(BrEq), .BrLT(BrLT),
        .ImmSel(ImmSel), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWEn(RegWEn), .WBSel(WBSel),
        .ASel(ASel), .BSel(BSel), .ALUOp(ALUOp), .BrUn(BrUn), .Illegal(Illegal),
        .InstRet(InstRet), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [2:0]  imm;
        logic        imm_chk;
        logic        irw, pcw, pcs, mrd, mwr, rwe;
        logic [1:0]  wbs;
        logic        as, bs;
        logic [1:0]  aop;
        logic        brun;
        logic        ill;
        logic [31:0] iret;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ret_cnt = 32'h0;
    int          cyc_no = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc_no, act, expv);
        end
    endtask

    always @(negedge clk) begin
        cyc_no++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("State", {29'h0, State}, {29'h0, e.st});
            if (e.imm_chk) check("ImmSel", {29'h0, ImmSel}, {29'h0, e.imm});
            check("IRWrite", {31'h0, IRWrite}, {31'h0, e.irw});
            check("PCWrite", {31'h0, PCWrite}, {31'h0, e.pcw});
            check("PCSel", {31'h0, PCSel}, {31'h0, e.pcs});
            check("MemRead", {31'h0, MemRead}, {31'h0, e.mrd});
            check("MemWrite", {31'h0, MemWrite}, {31'h0, e.mwr});
            check("RegWEn", {31'h0, RegWEn}, {31'h0, e.rwe});
            check("WBSel", {30'h0, WBSel}, {30'h0, e.wbs});
            check("ASel", {31'h0, ASel}, {31'h0, e.as});
            check("BSel", {31'h0, BSel}, {31'h0, e.bs});
            check("ALUOp", {30'h0, ALUOp}, {30'h0, e.aop});
            check("BrUn", {31'h0, BrUn}, {31'h0, e.brun});
            check("Illegal", {31'h0, Illegal}, {31'h0, e.ill});
            check("InstRet", InstRet, e.iret);
        end
    end

    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return (ins[14:13] == 2'b01) ? C_ILL : C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUI;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input int cls);
        case (cls)
            C_ST:         return 3'b001;
            C_BR:         return 3'b010;
            C_JAL:        return 3'b100;
            C_LUI, C_AUI: return 3'b101;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e.st = st; e.imm = 3'b000; e.imm_chk = 1'b0;
        e.irw = 0; e.pcw = 0; e.pcs = 0; e.mrd = 0; e.mwr = 0; e.rwe = 0;
        e.wbs = 2'b00; e.as = 0; e.bs = 0; e.aop = 2'b00; e.brun = 0; e.ill = 0;
        e.iret = ret_cnt;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic r, input logic [31:0] ins, input logic mr,
                         input logic beq, input logic blt, input exp_t e);
        rst = r; Inst = ins; MemReady = mr; BrEq = beq; BrLT = blt;
        e.brun = ins[13];
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic mr, input exp_t e);
        tick();
        apply(r, ins, mr, 1'($urandom), 1'($urandom), e);
    endtask

    task automatic run_inst(input logic [31:0] ins, input int fst, input int mst,
                            input int beq_force, input bit wrap, input bit rst_mem,
                            output int cycles);
        exp_t e;
        int   cls;
        logic beq, blt, tk;
        cls = classify(ins);
        cycles = 0;
        for (int i = 0; i < fst; i++) begin
            e = blank(3'b000); e.mrd = 1; e.imm_chk = 1;
            drive(0, $urandom, 0, e); cycles++;
        end
        e = blank(3'b000); e.mrd = 1; e.irw = 1; e.pcw = 1; e.imm_chk = 1;
        drive(0, $urandom, 1, e); cycles++;
        tick();
        if (wrap) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            ret_cnt = 32'hFFFF_FFFF;
        end
        e = blank(3'b001); e.imm = imm_of(cls); e.imm_chk = (cls != C_ILL);
        apply(0, ins, 1'($urandom), 1'($urandom), 1'($urandom), e); cycles++;
        if (cls == C_ILL) begin
            for (int i = 0; i < 10; i++) begin
                e = blank(3'b111); e.ill = 1;
                drive(0, ins, 1'($urandom), e); cycles++;
            end
            e = blank(3'b111); e.ill = 1;
            drive(1, ins, 1'($urandom), e); cycles++;
            ret_cnt = 32'h0;
            $display("txn inst=%08h class=%0d cycles=%0d instret=%08h (trap)", ins, cls, cycles, ret_cnt);
            return;
        end
        beq = (beq_force >= 0) ? 1'(beq_force) : 1'($urandom);
        blt = 1'($urandom);
        case (ins[14:12])
            3'b000:         tk = beq;
            3'b001:         tk = ~beq;
            3'b100, 3'b110: tk = blt;
            default:        tk = ~blt;
        endcase
        tick();
        if (wrap) release dut.instret_q;
        e = blank(3'b010); e.imm = imm_of(cls); e.imm_chk = 1;
        case (cls)
            C_R:    e.aop = 2'b10;
            C_I:    begin e.bs = 1; e.aop = 2'b10; end
            C_LD:   e.bs = 1;
            C_ST:   e.bs = 1;
            C_BR:   begin e.as = 1; e.bs = 1; e.pcw = tk; e.pcs = tk; end
            C_JAL:  begin e.as = 1; e.bs = 1; e.pcw = 1; e.pcs = 1; end
            C_JALR: begin e.bs = 1; e.pcw = 1; e.pcs = 1; end
            C_LUI:  begin e.bs = 1; e.aop = 2'b11; end
            default: begin e.as = 1; e.bs = 1; end
        endcase
        apply(0, ins, 1'($urandom), beq, blt, e); cycles++;
        if (cls == C_LD || cls == C_ST) begin
            for (int i = 0; i < mst; i++) begin
                e = blank(3'b011); e.mrd = (cls == C_LD); e.mwr = (cls == C_ST);
                drive(0, ins, 0, e); cycles++;
            end
            e = blank(3'b011); e.mrd = (cls == C_LD); e.mwr = (cls == C_ST);
            drive(rst_mem, ins, 1, e); cycles++;
            if (rst_mem) begin
                ret_cnt = 32'h0;
                $display("txn inst=%08h class=%0d cycles=%0d instret=%08h (reset)", ins, cls, cycles, ret_cnt);
                return;
            end
        end
        if (cls != C_BR && cls != C_ST) begin
            e = blank(3'b100); e.rwe = 1;
            e.wbs = (cls == C_LD) ? 2'b01 : ((cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00);
            drive(0, ins, 1'($urandom), e); cycles++;
        end
        ret_cnt = ret_cnt + 32'h1;
        $display("txn inst=%08h class=%0d cycles=%0d instret=%08h", ins, cls, cycles, ret_cnt);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) begin
            r[6:0] = ops[k];
            if (k == 4 && $urandom_range(0, 7) != 0)
                while (r[14:13] == 2'b01) r[14:12] = 3'($urandom);
        end else if (k == 9) begin
            while (classify(r) != C_ILL) r[6:0] = 7'($urandom);
        end else begin
            r[6:0] = ops[1];
        end
        return r;
    endfunction

    initial begin
        exp_t e;
        int   cyc;
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc_no);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   cyc;
        tick();
        e = blank(3'b000); e.mrd = 1; e.imm_chk = 1;
        apply(1, 32'h0, 0, 0, 0, e);

        run_inst(32'h00500093, 0, 0, -1, 0, 0, cyc);
        check("addi_cycles", cyc, 4);
        check("addi_instret", ret_cnt, 32'h1);
        run_inst(32'h0040A103, 3, 3, -1, 0, 0, cyc);
        check("load_stall_cycles", cyc, 11);
        run_inst(32'h00208463, 0, 0, 1, 0, 0, cyc);
        check("beq_taken_cycles", cyc, 3);
        run_inst(32'h00208463, 0, 0, 0, 0, 0, cyc);
        check("beq_not_taken_cycles", cyc, 3);
        run_inst(32'h008000EF, 0, 0, -1, 0, 0, cyc);
        check("jal_cycles", cyc, 4);
        run_inst(32'h123450B7, 0, 0, -1, 0, 0, cyc);
        check("lui_cycles", cyc, 4);
        check("instret_before_trap", ret_cnt, 32'h6);
        run_inst(32'h0000007F, 0, 0, -1, 0, 0, cyc);
        check("trap_cycles", cyc, 13);
        check("instret_after_trap_reset", ret_cnt, 32'h0);
        run_inst(32'h00500093, 0, 0, -1, 1, 0, cyc);
        check("wrap_instret", ret_cnt, 32'h0);
        run_inst(32'h0000A023, 1, 0, -1, 0, 0, cyc);
        check("store_cycles", cyc, 5);
        run_inst(32'h0020A023, 0, 2, -1, 0, 1, cyc);
        check("store_reset_cycles", cyc, 6);

        for (int n = 0; n < 300; n++) begin
            run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3), -1, 0, 0, cyc);
        end

        tick();
        e = blank(3'b000); e.mrd = 1; e.imm_chk = 1;
        apply(0, 32'h0, 0, 0, 0, e);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
